// File: rtl/grid_engine_pkg.sv
// Shared definitions for the grid engine: command opcodes, per-bank update
// modes, STATUS byte layout and a helper that assembles the STATUS byte.
package grid_engine_pkg;

   // Command opcodes, carried on ui_in[6:4]
   localparam logic [2:0] OP_NOP      = 3'd0;
   localparam logic [2:0] OP_SET_ADDR = 3'd1;
   localparam logic [2:0] OP_WRITE    = 3'd2;
   localparam logic [2:0] OP_READ     = 3'd3;
   localparam logic [2:0] OP_SET_MODE = 3'd4;
   localparam logic [2:0] OP_RUN      = 3'd5;
   localparam logic [2:0] OP_CLEAR    = 3'd6;
   localparam logic [2:0] OP_STATUS   = 3'd7;

   // Per-bank update modes
   localparam logic [1:0] M_HOLD = 2'd0;
   localparam logic [1:0] M_INC  = 2'd1;
   localparam logic [1:0] M_ROTL = 2'd2;
   localparam logic [1:0] M_XOR  = 2'd3;

   // STATUS byte layout: {busy, run, 4'b0, mode}
   localparam int ST_BUSY   = 7;
   localparam int ST_RUN    = 6;
   localparam int ST_MODE_L = 0;

   function automatic logic [7:0] status_byte(input logic busy,
                                              input logic run,
                                              input logic [1:0] mode);
      logic [7:0] s;
      s = 8'h00;
      s[ST_BUSY] = busy;
      s[ST_RUN] = run;
      s[ST_MODE_L +: 2] = mode;
      return s;
   endfunction

endpackage

// File: rtl/grid_engine_cell.sv
// One self-updating cell of the grid.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset (loads the seed INDEX)
//   run_en      - apply one evolution step on this edge
//   mode        - update mode of the bank this cell belongs to
//   wr_en       - host write; takes wr_data and skips evolution
//   wr_data     - host write data
//   clr_en      - sweep zeroes this cell on this edge
//   q           - cell value
// Priority: reset > clr_en > wr_en > run_en.
module grid_engine_cell
   import grid_engine_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int INDEX = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run_en,
   input  logic [1:0]       mode,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             clr_en,
   output logic [WIDTH-1:0] q
);

   localparam logic [WIDTH-1:0] SEED = WIDTH'(INDEX);

   // The shift form of the rotate degenerates to identity when WIDTH is 1.
   function automatic logic [WIDTH-1:0] evolve(input logic [1:0] m,
                                               input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] r;
      case (m)
         M_INC:   r = v + 1'b1;
         M_ROTL:  r = (v << 1) | (v >> (WIDTH - 1));
         M_XOR:   r = v ^ SEED;
         default: r = v;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q <= SEED;
      end else if (clr_en) begin
         q <= '0;
      end else if (wr_en) begin
         q <= wr_data;
      end else if (run_en) begin
         q <= evolve(mode, q);
      end
   end

endmodule

// File: rtl/tt_um_bluewatercrystal_grid_engine.sv
// Banked grid of self-updating cells behind a byte-wide command port.
// Ports:
//   clk, rst_n - clock, synchronous active-low reset
//   ena        - unused
//   ui_in      - command: [7] strobe, [6:4] opcode, [3:0] arg
//   uio_in     - data / address byte
//   uo_out     - response register (READ / STATUS results)
//   uio_out    - tied 0
//   uio_oe     - tied 0
// A command fires on the first cycle ui_in[7] is seen high after being low.
module tt_um_bluewatercrystal_grid_engine
   import grid_engine_pkg::*;
#(
   parameter int BANKS = 4,
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   localparam int         N      = BANKS * DEPTH;
   localparam logic [8:0] N9     = 9'(N);
   localparam logic [7:0] LAST   = 8'(N - 1);
   localparam logic [7:0] DEPTH8 = 8'(DEPTH);

   logic             strb_q;
   logic             fire;
   logic             cmd_ok;
   logic [2:0]       opcode;
   logic [3:0]       arg;
   logic [7:0]       addr;
   logic [7:0]       addr_next;
   logic             addr_ok;
   logic             run;
   logic             busy;
   logic [7:0]       sweep;
   logic [1:0]       mode [BANKS];
   logic [WIDTH-1:0] cell_q [N];
   logic [7:0]       rd_byte;
   logic [7:0]       bank_sel;
   logic [1:0]       stat_mode;
   logic [7:0]       stat_byte;
   logic             unused_bits;

   assign opcode = ui_in[6:4];
   assign arg    = ui_in[3:0];
   assign fire   = ui_in[7] & ~strb_q;
   // Everything except STATUS is dropped while the clear sweep is running.
   assign cmd_ok = fire & ~busy;

   assign addr_ok   = ({1'b0, addr} < N9);
   assign addr_next = (addr == LAST) ? 8'd0 : addr + 8'd1;
   assign bank_sel  = addr / DEPTH8;

   // Out-of-range addresses match no cell and read as zero.
   always_comb begin
      rd_byte = 8'h00;
      for (int i = 0; i < N; i++) begin
         if (addr == 8'(i)) rd_byte = 8'(cell_q[i]);
      end
   end

   always_comb begin
      stat_mode = M_HOLD;
      for (int b = 0; b < BANKS; b++) begin
         if (addr_ok && bank_sel == 8'(b)) stat_mode = mode[b];
      end
   end

   assign stat_byte = status_byte(busy, run, stat_mode);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         strb_q <= 1'b0;
         addr   <= 8'h00;
         run    <= 1'b0;
         busy   <= 1'b0;
         sweep  <= 8'h00;
         uo_out <= 8'h00;
         for (int b = 0; b < BANKS; b++) mode[b] <= M_HOLD;
      end else begin
         strb_q <= ui_in[7];

         // busy drops on the same edge that zeroes the last cell
         if (busy) begin
            if (sweep == LAST) busy <= 1'b0;
            sweep <= sweep + 8'd1;
         end

         if (fire && opcode == OP_STATUS) uo_out <= stat_byte;

         if (cmd_ok) begin
            case (opcode)
               OP_SET_ADDR: addr <= uio_in;
               OP_WRITE: begin
                  if (arg[0]) addr <= addr_next;
               end
               OP_READ: begin
                  uo_out <= rd_byte;
                  if (arg[0]) addr <= addr_next;
               end
               OP_SET_MODE: begin
                  for (int b = 0; b < BANKS; b++) begin
                     if (uio_in == 8'(b)) mode[b] <= arg[1:0];
                  end
               end
               OP_RUN: run <= arg[0];
               OP_CLEAR: begin
                  busy  <= 1'b1;
                  sweep <= 8'h00;
               end
               default: ;
            endcase
         end
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_cell
      logic wr_hit;
      logic clr_hit;
      assign wr_hit  = cmd_ok && (opcode == OP_WRITE) && (addr == 8'(i));
      assign clr_hit = busy && (sweep == 8'(i));

      grid_engine_cell #(
         .WIDTH (WIDTH),
         .INDEX (i)
      ) u_cell (
         .clk     (clk),
         .rst_n   (rst_n),
         .run_en  (run & ~busy),
         .mode    (mode[i / DEPTH]),
         .wr_en   (wr_hit),
         .wr_data (uio_in[WIDTH-1:0]),
         .clr_en  (clr_hit),
         .q       (cell_q[i])
      );
   end

   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

   assign unused_bits = &{1'b0, ena, arg[3:2], uio_in};

endmodule

// File: tb/tb_tt_um_bluewatercrystal_grid_engine.sv
module tb_tt_um_bluewatercrystal_grid_engine;
   import grid_engine_pkg::*;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] op;
      logic [3:0] arg;
      logic [7:0] data;
      bit         chk;
      logic [7:0] exp;
      int         gap;
      string      name;
   } vec_t;

   vec_t vecs[$];

   tt_um_bluewatercrystal_grid_engine dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic add(input logic [2:0] op, input logic [3:0] arg,
                      input logic [7:0] data, input bit chk,
                      input logic [7:0] exp, input int gap, input string name);
      vec_t v;
      v.op = op; v.arg = arg; v.data = data; v.chk = chk;
      v.exp = exp; v.gap = gap; v.name = name;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
      end
   endtask

   // Strobe high for one cycle, then low; response sampled on the negedge
   // following the firing posedge.
   task automatic do_cmd(input vec_t v);
      @(negedge clk);
      ui_in  = {1'b1, v.op, v.arg};
      uio_in = v.data;
      @(negedge clk);
      ui_in[7] = 1'b0;
      if (v.chk) check(v.name, uo_out, v.exp);
      repeat (v.gap) @(negedge clk);
   endtask

   task automatic run_range(input int lo, input int hi);
      for (int k = lo; k < hi; k++) do_cmd(vecs[k]);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      ui_in = 8'h00;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int seg_a, seg_b, seg_c, seg_d;

      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = 8'h00;

      // Seed read, write/read with auto-increment, wrap and out-of-range
      add(OP_SET_ADDR, 4'h0, 8'h05, 0, 8'h00, 0, "");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h05, 0, "seed_rd_05");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h00, 0, "status_reset");
      add(OP_SET_ADDR, 4'h0, 8'h10, 1, 8'h00, 0, "uo_hold_setaddr");
      add(OP_WRITE,    4'h1, 8'hA5, 0, 8'h00, 0, "");
      add(OP_WRITE,    4'h1, 8'h3C, 0, 8'h00, 0, "");
      add(OP_SET_ADDR, 4'h0, 8'h10, 0, 8'h00, 0, "");
      add(OP_READ,     4'h1, 8'h00, 1, 8'hA5, 0, "wr_rd_10");
      add(OP_READ,     4'h1, 8'h00, 1, 8'h3C, 0, "wr_rd_11");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h12, 0, "seed_rd_12");
      add(OP_SET_ADDR, 4'h0, 8'h3F, 0, 8'h00, 0, "");
      add(OP_READ,     4'h1, 8'h00, 1, 8'h3F, 0, "rd_3f");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h00, 0, "rd_wrap_00");
      add(OP_SET_ADDR, 4'h0, 8'h40, 0, 8'h00, 0, "");
      add(OP_WRITE,    4'h0, 8'h99, 0, 8'h00, 0, "");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h00, 0, "rd_oor");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h00, 0, "status_oor");
      add(OP_SET_ADDR, 4'h0, 8'h3F, 0, 8'h00, 0, "");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h3F, 0, "rd_3f_after_oor_wr");
      seg_a = vecs.size();

      // Modes: three updates between RUN(1) and RUN(0); then write priority
      add(OP_SET_MODE, 4'h1, 8'h01, 0, 8'h00, 0, "");
      add(OP_SET_MODE, 4'h2, 8'h02, 0, 8'h00, 0, "");
      add(OP_SET_MODE, 4'h3, 8'h03, 0, 8'h00, 0, "");
      add(OP_SET_MODE, 4'h3, 8'h04, 0, 8'h00, 0, "");
      add(OP_SET_ADDR, 4'h0, 8'h05, 0, 8'h00, 0, "");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h00, 0, "status_bank0_hold");
      add(OP_SET_ADDR, 4'h0, 8'h30, 0, 8'h00, 0, "");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h03, 0, "status_bank3_xor");
      add(OP_RUN,      4'h1, 8'h00, 0, 8'h00, 1, "");
      add(OP_RUN,      4'h0, 8'h00, 0, 8'h00, 0, "");
      add(OP_SET_ADDR, 4'h0, 8'h10, 0, 8'h00, 0, "");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h13, 0, "inc_10");
      add(OP_SET_ADDR, 4'h0, 8'h20, 0, 8'h00, 0, "");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h01, 0, "rotl_20");
      add(OP_SET_ADDR, 4'h0, 8'h31, 0, 8'h00, 0, "");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h00, 0, "xor_31");
      add(OP_SET_ADDR, 4'h0, 8'h05, 0, 8'h00, 0, "");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h05, 0, "hold_05");
      add(OP_SET_ADDR, 4'h0, 8'h11, 0, 8'h00, 0, "");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h14, 0, "inc_11");
      add(OP_SET_ADDR, 4'h0, 8'h12, 0, 8'h00, 0, "");
      add(OP_RUN,      4'h1, 8'h00, 0, 8'h00, 0, "");
      add(OP_WRITE,    4'h0, 8'h77, 0, 8'h00, 0, "");
      add(OP_RUN,      4'h0, 8'h00, 0, 8'h00, 0, "");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h79, 0, "wr_priority_12");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h01, 0, "status_halted_bank1");
      seg_b = vecs.size();

      // CLEAR: fire at edge E0, STATUS at E2, dropped WRITE at E4, STATUS at
      // E64 (last busy cycle); second CLEAR, STATUS 65 edges later (idle).
      add(OP_SET_ADDR, 4'h0, 8'h35, 0, 8'h00, 0, "");
      add(OP_CLEAR,    4'h0, 8'h00, 0, 8'h00, 0, "");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h83, 0, "status_busy_early");
      add(OP_WRITE,    4'h1, 8'h55, 0, 8'h00, 58, "");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h83, 0, "status_busy_cycle64");
      add(OP_CLEAR,    4'h0, 8'h00, 0, 8'h00, 63, "");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h03, 0, "status_idle_cycle65");
      add(OP_SET_ADDR, 4'h0, 8'h10, 0, 8'h00, 0, "");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h01, 0, "status_mode1_kept");
      add(OP_SET_ADDR, 4'h0, 8'h20, 0, 8'h00, 0, "");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h02, 0, "status_mode2_kept");
      add(OP_SET_ADDR, 4'h0, 8'h00, 0, 8'h00, 0, "");
      for (int i = 0; i < 64; i++)
         add(OP_READ, 4'h1, 8'h00, 1, 8'h00, 0, $sformatf("clr_rd_%0d", i));
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h00, 0, "status_addr_wrapped");
      add(OP_SET_ADDR, 4'h0, 8'h35, 0, 8'h00, 0, "");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h03, 0, "status_mode3_kept");
      add(OP_RUN,      4'h1, 8'h00, 0, 8'h00, 0, "");
      add(OP_CLEAR,    4'h0, 8'h00, 0, 8'h00, 10, "");
      seg_c = vecs.size();

      // After mid-sweep reset
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h00, 0, "rst_status_bank0");
      add(OP_SET_ADDR, 4'h0, 8'h10, 0, 8'h00, 0, "");
      add(OP_STATUS,   4'h0, 8'h00, 1, 8'h00, 0, "rst_status_bank1");
      add(OP_SET_ADDR, 4'h0, 8'h2A, 0, 8'h00, 0, "");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h2A, 3, "rst_seed_2a");
      add(OP_SET_ADDR, 4'h0, 8'h12, 0, 8'h00, 0, "");
      add(OP_READ,     4'h0, 8'h00, 1, 8'h12, 0, "rst_seed_12");
      seg_d = vecs.size();

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("reset_uo_out", uo_out, 8'h00);
      check("uio_out_zero", uio_out, 8'h00);
      check("uio_oe_zero", uio_oe, 8'h00);

      run_range(0, seg_a);
      do_reset();
      run_range(seg_a, seg_b);
      run_range(seg_b, seg_c);
      do_reset();
      check("reset_mid_clear_uo_out", uo_out, 8'h00);
      run_range(seg_c, seg_d);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/tt_um_bluewatercrystal_grid_engine.md
# tt_um_bluewatercrystal_grid_engine

Parametrised, host-accessible successor to the sexy_grid register fabric. It holds a banked array of self-updating cells. Each bank runs its own update mode: hold, increment, rotate or XOR. A byte-wide command port on the Tiny Tapeout pins gives read/write access, run/halt control, per-bank mode selection and a bulk-clear sweep. It is a standalone TT user top.

## Interface
Parameters:
- BANKS, 4: number of banks.
- DEPTH, 16: cells per bank. N = BANKS*DEPTH must be ≤ 256.
- WIDTH, 8: cell width, 1..8. Narrower cells are zero-extended on uo_out and take uio_in[WIDTH-1:0] on write.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  reset, synchronous, active-low.
- ena  in  1  ignored.
- ui_in  in  8  command: [7] strobe, [6:4] opcode, [3:0] arg.
- uio_in  in  8  data/address byte.
- uo_out  out  8  response register.
- uio_out  out  8  tied 0.
- uio_oe  out  8  tied 0.

## Operation
- Command fire: fire = ui_in[7] & ~strb_q, where strb_q is ui_in[7] registered. A fire is one cycle wide and the command acts on that cycle's closing edge. Each command needs ui_in[7] low, then high.
- Opcodes:
  - 0 NOP.
  - 1 SET_ADDR: addr ← uio_in.
  - 2 WRITE: cell[addr] ← uio_in. Auto-increments addr if arg[0].
  - 3 READ: uo_out ← cell[addr], using the pre-edge value. Auto-increments addr if arg[0].
  - 4 SET_MODE: mode[uio_in] ← arg[1:0]. Ignored if uio_in ≥ BANKS.
  - 5 RUN: run ← arg[0].
  - 6 CLEAR: starts the sweep.
  - 7 STATUS: uo_out ← {busy, run, 4'b0, mode[bank of addr]}. Bank index is addr/DEPTH. Reads 0 if addr ≥ N.
- addr range: addr ≥ N makes WRITE a no-op and READ return 0x00. Auto-increment wraps N-1 → 0.
- Cell i belongs to bank i/DEPTH. When run=1 and busy=0, every cell updates each edge according to its bank's mode:
  - 0 HOLD: no change.
  - 1 INC: +1, modulo 2^WIDTH.
  - 2 ROTL: rotate left by 1 within WIDTH.
  - 3 XOR: cell ^ i[WIDTH-1:0].
- Host WRITE beats evolution: the addressed cell takes uio_in and skips its update on that edge.
- CLEAR: busy ← 1 and sweep index ← 0. One cell is zeroed per cycle, indices 0..N-1. busy falls on the edge that zeroes cell N-1, so busy is high for exactly N cycles. Modes and run are unchanged. Evolution is suspended while busy.
- While busy, every fired command except STATUS is dropped with no side effects.

## Timing
- Reset values:
  - cell[i] = i[WIDTH-1:0] (seed pattern).
  - mode = HOLD for all banks.
  - run = 0, busy = 0, addr = 0, strb_q = 0, uo_out = 0x00.
- Reset wins over everything, including a mid-CLEAR sweep or running evolution. The state after reset is identical to power-on reset.
- READ/STATUS latency: if fire occurs in cycle t, uo_out holds the value from t+1 until the next READ/STATUS. uo_out is unchanged by other commands.
- RUN: a RUN(1) fire at cycle t and a RUN(0) fire at cycle t+k produce exactly k updates. The run flag's pre-edge value gates each update.
- The sweep does not block evolution ordering; it only suspends it.

## Structure
- Package grid_engine_pkg holds:
  - opcode localparams OP_NOP..OP_STATUS;
  - mode localparams M_HOLD/M_INC/M_ROTL/M_XOR;
  - STATUS bit positions.
- Sub-module grid_engine_cell(WIDTH, INDEX), instantiated N times in a generate loop. Its ports:
  - inputs: clk, rst_n, run_en, mode, wr_en, wr_data, clr_en;
  - output: q.
  - It owns the seed, the update function and the priority order: reset > clr_en > wr_en > run_en.
- The top holds the command decoder, addr, mode registers, sweep counter, read mux and uo_out.

## Test plan
Default parameters: N = 64, WIDTH = 8.
- Seed read: after reset, SET_ADDR 0x05, READ → uo_out = 0x05. STATUS → 0x00.
- Write/read with auto-increment: SET_ADDR 0x10, WRITE 0xA5 (arg 1), WRITE 0x3C (arg 1), SET_ADDR 0x10, READ×2 (arg 1) → 0xA5 then 0x3C. SET_ADDR 0x3F, READ (arg 1), READ → cell 63 = 0x3F, then cell 0 = 0x00 (wrap).
- Modes: SET_MODE bank1=INC, bank2=ROTL, bank3=XOR, then RUN(1) at t and RUN(0) at t+3. Expected reads:
  - cell 0x10 → 0x13;
  - cell 0x20 → 0x01 (0x20→0x40→0x80→0x01);
  - cell 0x31 → 0x00 (three XORs);
  - cell 0x05 → 0x05 (bank0 HOLD).
- Write priority: in INC mode while running, WRITE 0x77 to 0x12, then HALT on the next fire. Cell 0x12 = 0x77 + (updates after the write edge).
- CLEAR: fire CLEAR.
  - STATUS during the sweep → bit7 = 1.
  - A WRITE during the sweep is dropped.
  - busy is high for exactly 64 cycles.
  - Afterwards all 64 reads return 0x00, and modes are intact per STATUS.
- Reset mid-operation: pulse rst_n low for 1 cycle mid-CLEAR with run = 1. Expect busy = 0, run = 0, all modes HOLD, and cell 0x2A reads 0x2A.
